// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle core: sequencer states, opcode map,
// latched decoder controls and the sequencer's registered output bundle.
package mips_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } seq_state_t;

  localparam logic [4:0] OP_AND    = 5'b00000;
  localparam logic [4:0] OP_OR     = 5'b00001;
  localparam logic [4:0] OP_SUB    = 5'b00010;
  localparam logic [4:0] OP_ADD    = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_CMP    = 5'b00101;
  localparam logic [4:0] OP_MOV    = 5'b00110;
  localparam logic [4:0] OP_ADDI   = 5'b00111;
  localparam logic [4:0] OP_SUBI   = 5'b01000;
  localparam logic [4:0] OP_LW     = 5'b01001;
  localparam logic [4:0] OP_SW     = 5'b01010;
  localparam logic [4:0] OP_BEQ    = 5'b01011;
  localparam logic [4:0] OP_J      = 5'b01100;
  localparam logic [4:0] OP_JR     = 5'b01101;
  localparam logic [4:0] OP_ANDI   = 5'b01110;
  localparam logic [4:0] OP_ORI    = 5'b01111;
  localparam logic [4:0] OP_SUBISF = 5'b10000;
  localparam logic [4:0] OP_MAX    = OP_SUBISF;

  // Decoder levels captured in DECODE; EXEC rewrites the flags the decoder predicates on.
  typedef struct packed {
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
    logic sf_en;
  } ctl_lat_t;

  typedef struct packed {
    logic busy;
    logic imem_req;
    logic dmem_req;
    logic dmem_rw;
    logic flag_we;
    logic rf_we;
    logic pc_we;
  } seq_out_t;

  function automatic logic is_mem(input ctl_lat_t c);
    return c.mem_rd | c.mem_wr;
  endfunction

endpackage

// File: rtl/instr_stage_sequencer_if.sv
// Instruction- and data-memory handshake bundle between the sequencer
// (master) and the memory subsystem (slave).
interface instr_stage_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_rw;
  logic dmem_ack;

  modport master (output imem_req, dmem_req, dmem_rw, input imem_ack, dmem_ack);
  modport slave  (input imem_req, dmem_req, dmem_rw, output imem_ack, dmem_ack);
endinterface

// File: rtl/seq_perf_counters.sv
// Retired-instruction and memory-stall counters; the module only exists when
// SEQ_PERF_CNT_EN is defined, so the default build carries no counter flops.
`ifdef SEQ_PERF_CNT_EN
module seq_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             retire_i,
  input  logic             stall_i,
  output logic [CNT_W-1:0] retired_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [CNT_W-1:0] retired_q, stall_q;

  // Both counters wrap modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (retire_i) retired_q <= retired_q + CNT_W'(1);
      if (stall_i)  stall_q   <= stall_q + CNT_W'(1);
    end
  end

  assign retired_cnt_o = retired_q;
  assign stall_cnt_o   = stall_q;

endmodule
`endif

// File: rtl/instr_stage_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer turning decoder levels into one-cycle strobes.
// Build option SEQ_PERF_CNT_EN enables the retired/stall counters; otherwise they read 0.
module instr_stage_sequencer
  import mips_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    run,
  input  logic [OPCODE_W-1:0]     opcode,
  input  logic                    cu_reg_wr,
  input  logic                    cu_mem_rd,
  input  logic                    cu_mem_wr,
  input  logic                    cu_sf_en,
  instr_stage_sequencer_if.master mem_if,
  output logic                    ir_we,
  output logic                    mdr_we,
  output logic                    flag_we,
  output logic                    rf_we,
  output logic                    pc_we,
  output logic                    illegal_op,
  output logic                    busy,
  output logic [CNT_W-1:0]        retired_cnt,
  output logic [CNT_W-1:0]        stall_cnt
);

  seq_state_t state_q, state_d, instr_end;
  ctl_lat_t   lat_q, lat_d;
  seq_out_t   out_q, out_d;
  logic       op_illegal, fetch_ack, mem_ack;

  assign instr_end  = run ? S_FETCH : S_IDLE;
  assign op_illegal = (state_q == S_DECODE) && (opcode > OPCODE_W'(OP_MAX));
  assign fetch_ack  = (state_q == S_FETCH) && mem_if.imem_ack;
  assign mem_ack    = (state_q == S_MEM) && mem_if.dmem_ack;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (mem_if.imem_ack) state_d = S_DECODE;
      S_DECODE: begin
        lat_d   = '{reg_wr: cu_reg_wr, mem_rd: cu_mem_rd, mem_wr: cu_mem_wr, sf_en: cu_sf_en};
        state_d = op_illegal ? instr_end : S_EXEC;
      end
      S_EXEC: begin
        if (is_mem(lat_q))     state_d = S_MEM;
        else if (lat_q.reg_wr) state_d = S_WB;
        else                   state_d = instr_end;
      end
      S_MEM:    if (mem_if.dmem_ack) state_d = lat_q.mem_wr ? instr_end : S_WB;
      S_WB:     state_d = instr_end;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs that depend only on the state being entered are registered with it.
  always_comb begin
    out_d          = '0;
    out_d.busy     = (state_d != S_IDLE);
    out_d.imem_req = (state_d == S_FETCH);
    out_d.dmem_req = (state_d == S_MEM);
    out_d.dmem_rw  = (state_d == S_MEM) && lat_d.mem_wr;
    out_d.flag_we  = (state_d == S_EXEC) && lat_d.sf_en;
    out_d.rf_we    = (state_d == S_WB) && lat_d.reg_wr;
    out_d.pc_we    = (state_d == S_WB) ||
                     ((state_d == S_EXEC) && !is_mem(lat_d) && !lat_d.reg_wr);
  end

  // NOTE: synchronous reset, and non-blocking updates so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      out_q   <= out_d;
    end
  end

  assign mem_if.imem_req = out_q.imem_req;
  assign mem_if.dmem_req = out_q.dmem_req;
  assign mem_if.dmem_rw  = out_q.dmem_rw;
  assign busy            = out_q.busy;
  assign flag_we         = out_q.flag_we;
  assign rf_we           = out_q.rf_we;

  // Ack- and opcode-qualified strobes fire in the same cycle; reset suppresses them.
  assign ir_we      = fetch_ack && reset_n;
  assign mdr_we     = mem_ack && !lat_q.mem_wr && reset_n;
  assign illegal_op = op_illegal && reset_n;
  assign pc_we      = out_q.pc_we || (reset_n && ((mem_ack && lat_q.mem_wr) || op_illegal));

`ifdef SEQ_PERF_CNT_EN
  logic stall_cyc;
  assign stall_cyc = ((state_q == S_FETCH) && !mem_if.imem_ack) ||
                     ((state_q == S_MEM) && !mem_if.dmem_ack);

  seq_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk           (clk),
    .reset_n       (reset_n),
    .retire_i      (pc_we),
    .stall_i       (stall_cyc),
    .retired_cnt_o (retired_cnt),
    .stall_cnt_o   (stall_cnt)
  );
`else
  assign retired_cnt = '0;
  assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_instr_stage_sequencer.sv
// Self-checking bench: per-instruction cycle plans built from the stage rules,
// applied cycle by cycle with random ack delays, decoder noise and reset aborts.
module tb_instr_stage_sequencer;
  import mips_pkg::*;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, run, cu_reg_wr, cu_mem_rd, cu_mem_wr, cu_sf_en;
  logic [4:0]       opcode;
  logic             ir_we, mdr_we, flag_we, rf_we, pc_we, illegal_op, busy;
  logic [CNT_W-1:0] retired_cnt, stall_cnt;

  instr_stage_sequencer_if mem_if ();

  instr_stage_sequencer #(.OPCODE_W(5), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .opcode      (opcode),
    .cu_reg_wr   (cu_reg_wr),
    .cu_mem_rd   (cu_mem_rd),
    .cu_mem_wr   (cu_mem_wr),
    .cu_sf_en    (cu_sf_en),
    .mem_if      (mem_if),
    .ir_we       (ir_we),
    .mdr_we      (mdr_we),
    .flag_we     (flag_we),
    .rf_we       (rf_we),
    .pc_we       (pc_we),
    .illegal_op  (illegal_op),
    .busy        (busy),
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
  );

  typedef struct packed {
    logic busy, imem_req, dmem_req, dmem_rw, ir_we, mdr_we, flag_we, rf_we, pc_we, illegal_op;
  } exp_t;

  // One clock cycle of stimulus plus what the outputs must show during it.
  typedef struct {
    logic       rst_n;
    logic       run;
    logic [4:0] op;
    logic [3:0] cu;     // {reg_wr, mem_rd, mem_wr, sf_en}
    logic       iack;
    logic       dack;
    logic       stall;
    exp_t       exp;
  } cyc_t;

  cyc_t             plan[$];
  int               vectors = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] m_retired = '0;
  logic [CNT_W-1:0] m_stall = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Busy cycle with random run/opcode/decoder noise; callers fix what matters.
  function automatic cyc_t new_cyc();
    cyc_t c;
    c.rst_n = 1'b1;
    c.run   = 1'($urandom);
    c.op    = 5'($urandom);
    c.cu    = 4'($urandom);
    c.iack  = 1'b0;
    c.dack  = 1'b0;
    c.stall = 1'b0;
    c.exp   = '0;
    c.exp.busy = 1'b1;
    return c;
  endfunction

  task automatic push_idle(input logic r);
    cyc_t c;
    c = new_cyc();
    c.exp = '0;
    c.run = r;
    plan.push_back(c);
  endtask

  task automatic after_instr(input bit run_end);
    int n;
    if (!run_end) begin
      n = $urandom_range(0, 2);
      repeat (n) push_idle(1'b0);
      push_idle(1'b1);
    end
  endtask

  // Plans one instruction: id/dd are extra imem/dmem wait cycles; rst_k >= 0
  // asserts reset in that MEM wait cycle (must be < dd).
  task automatic add_instr(input logic [4:0] op, input logic [3:0] cu, input int id,
                           input int dd, input bit run_end, input int rst_k);
    cyc_t c;
    for (int k = 0; k <= id; k++) begin
      c = new_cyc();
      c.exp.imem_req = 1'b1;
      c.iack         = (k == id);
      c.exp.ir_we    = (k == id);
      c.stall        = (k < id);
      plan.push_back(c);
    end
    c = new_cyc();
    c.op = op;
    c.cu = cu;
    if (op > 5'd16) begin
      c.exp.illegal_op = 1'b1;
      c.exp.pc_we      = 1'b1;
      c.run            = run_end;
      plan.push_back(c);
      after_instr(run_end);
      return;
    end
    plan.push_back(c);
    c = new_cyc();
    c.op = op;
    c.exp.flag_we = cu[0];
    if (cu[2] || cu[1]) begin
      plan.push_back(c);
      for (int k = 0; k <= dd; k++) begin
        c = new_cyc();
        c.op = op;
        c.exp.dmem_req = 1'b1;
        c.exp.dmem_rw  = cu[1];
        c.dack         = (k == dd);
        c.stall        = (k < dd);
        if (k == rst_k) begin
          c.rst_n = 1'b0;
          plan.push_back(c);
          after_instr(1'b0);
          return;
        end
        if (k == dd) begin
          if (cu[1]) begin
            c.exp.pc_we = 1'b1;
            c.run       = run_end;
            plan.push_back(c);
            after_instr(run_end);
            return;
          end
          c.exp.mdr_we = 1'b1;
        end
        plan.push_back(c);
      end
    end else if (!cu[3]) begin
      c.exp.pc_we = 1'b1;
      c.run       = run_end;
      plan.push_back(c);
      after_instr(run_end);
      return;
    end else begin
      plan.push_back(c);
    end
    c = new_cyc();
    c.op = op;
    c.exp.rf_we = cu[3];
    c.exp.pc_we = 1'b1;
    c.run       = run_end;
    plan.push_back(c);
    after_instr(run_end);
  endtask

  task automatic execute();
    cyc_t c;
    exp_t got;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(posedge clk);
      #1;
      reset_n         = c.rst_n;
      run             = c.run;
      opcode          = c.op;
      {cu_reg_wr, cu_mem_rd, cu_mem_wr, cu_sf_en} = c.cu;
      mem_if.imem_ack = c.iack;
      mem_if.dmem_ack = c.dack;
      @(negedge clk);
      got = '{busy, mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_rw & mem_if.dmem_req,
              ir_we, mdr_we, flag_we, rf_we, pc_we, illegal_op};
      check("outputs", 64'(got), 64'(c.exp));
`ifdef SEQ_PERF_CNT_EN
      check("retired_cnt", 64'(retired_cnt), 64'(m_retired));
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`else
      check("retired_cnt", 64'(retired_cnt), 64'(0));
      check("stall_cnt", 64'(stall_cnt), 64'(0));
`endif
      if (!c.rst_n) begin
        m_retired = '0;
        m_stall   = '0;
      end else begin
        m_retired = m_retired + CNT_W'(c.exp.pc_we);
        m_stall   = m_stall + CNT_W'(c.stall);
      end
    end
  endtask

  initial begin
    int         cls, id, dd, rk;
    bit         re;
    logic [3:0] cu;
    logic [4:0] op;

    reset_n = 1'b0;
    run = 1'b0;
    opcode = '0;
    {cu_reg_wr, cu_mem_rd, cu_mem_wr, cu_sf_en} = 4'b0;
    mem_if.imem_ack = 1'b0;
    mem_if.dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", 64'({busy, mem_if.imem_req, mem_if.dmem_req, ir_we, mdr_we,
                                flag_we, rf_we, pc_we, illegal_op}), 64'(0));
    check("reset_counters", 64'({retired_cnt, stall_cnt}), 64'(0));

    push_idle(1'b0);
    push_idle(1'b1);
    add_instr(OP_ADD, 4'b1000, 0, 0, 1'b1, -1);      // F,D,E,W
    add_instr(OP_LW, 4'b1100, 0, 3, 1'b1, -1);       // dmem ack 3 late
    add_instr(OP_SW, 4'b0010, 0, 0, 1'b1, -1);
    add_instr(OP_CMP, 4'b0001, 0, 0, 1'b1, -1);
    add_instr(5'b11111, 4'b1111, 0, 0, 1'b1, -1);
    add_instr(OP_ADD, 4'b1001, 1, 0, 1'b0, -1);      // run drops -> IDLE
    add_instr(OP_LW, 4'b1100, 0, 5, 1'b0, 2);        // reset while waiting in MEM
    execute();

    for (int n = 0; n < 200; n++) begin
      cls = $urandom_range(0, 6);
      id  = $urandom_range(0, 3);
      dd  = $urandom_range(0, 3);
      re  = ($urandom_range(0, 3) != 0);
      rk  = -1;
      op  = 5'($urandom_range(0, 16));
      case (cls)
        0:       cu = {1'b1, 2'b00, 1'($urandom)};
        1:       cu = {1'($urandom), 1'b1, 1'b0, 1'b0};
        2:       cu = 4'b0010;
        3:       cu = {3'b000, 1'($urandom)};
        4:       cu = 4'b0000;
        5: begin
          op = 5'($urandom_range(17, 31));
          cu = 4'($urandom);
        end
        default: begin
          cu = ($urandom_range(0, 1) != 0) ? 4'b1100 : 4'b0010;
          dd = $urandom_range(1, 4);
          rk = $urandom_range(0, dd - 1);
        end
      endcase
      add_instr(op, cu, id, dd, re, rk);
      execute();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
